// File: rtl/plot_reader.sv
// plot_reader
//   Holds a WIDTH x HEIGHT framebuffer of 3-bit pixels. A drawing block
//   writes pixels into it through the VGA_* plot port. On a start pulse the
//   block streams the whole buffer out in raster order over a valid/ready
//   handshake. After reset the buffer is zero-filled before anything else
//   is accepted.
//
// Ports
//   CLOCK_50     in   clock, all logic on the rising edge
//   resetn       in   asynchronous active-low reset
//   VGA_X/Y      in   plot column (8b) / row (7b)
//   VGA_COLOUR   in   plot colour (3b)
//   VGA_PLOT     in   plot write strobe, one pixel per cycle
//   start        in   scan request pulse, honoured only when idle
//   out_x/out_y  out  column / row of the pixel on offer
//   out_colour   out  colour of the pixel on offer
//   out_valid    out  pixel on offer
//   out_ready    in   consumer takes the pixel
//   busy         out  clearing or scanning
//   done         out  one-cycle pulse after the final pixel transfer
//   plot_count   out  accepted plots, saturating at 16'hFFFF
//   reject_count out  out-of-range plots, saturating at 16'hFFFF
module plot_reader #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [7:0]  VGA_X,
  input  logic [6:0]  VGA_Y,
  input  logic [2:0]  VGA_COLOUR,
  input  logic        VGA_PLOT,
  input  logic        start,
  output logic [7:0]  out_x,
  output logic [6:0]  out_y,
  output logic [2:0]  out_colour,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] plot_count,
  output logic [15:0] reject_count
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [7:0]    X_LAST    = 8'(WIDTH - 1);
  localparam logic [6:0]    Y_LAST    = 7'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_READ  = 2'd2,
    S_SEND  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pix_t;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic          done_q, done_d;
  logic [15:0]   plot_cnt_q, plot_cnt_d;
  logic [15:0]   rej_cnt_q, rej_cnt_d;

  // framebuffer and its registered read port
  logic [2:0]    fb [NPIX];
  logic [2:0]    rd_data_q;

  logic          plot_in_range, plot_wr, plot_rej;
  logic [AW-1:0] plot_addr, scan_addr;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [2:0]    mem_wd;
  logic          rd_en;
  logic          last_pix;
  pix_t          out_pix;

  // ------------------------------------------------------------------
  // plot port decode; the clear sweep owns the write port so plots are
  // dropped (and not counted) while it runs
  // ------------------------------------------------------------------
  assign plot_in_range = (int'(VGA_X) < WIDTH) && (int'(VGA_Y) < HEIGHT);
  assign plot_addr     = AW'(int'(VGA_Y) * WIDTH + int'(VGA_X));
  assign scan_addr     = AW'(int'(y_q) * WIDTH + int'(x_q));
  assign plot_wr       = VGA_PLOT && (state_q != S_CLEAR) && plot_in_range;
  assign plot_rej      = VGA_PLOT && (state_q != S_CLEAR) && !plot_in_range;

  assign mem_we = (state_q == S_CLEAR) || plot_wr;
  assign mem_wa = (state_q == S_CLEAR) ? clr_addr_q : plot_addr;
  assign mem_wd = (state_q == S_CLEAR) ? 3'd0 : VGA_COLOUR;
  assign rd_en  = (state_q == S_READ);

  // Read and write share one edge; the non-blocking read samples the old
  // contents, so a same-address plot is seen only by the next scan.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) fb[mem_wa] <= mem_wd;
    if (rd_en)  rd_data_q  <= fb[scan_addr];
  end

  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

  // ------------------------------------------------------------------
  // next-state / datapath
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    x_d        = x_q;
    y_d        = y_q;
    done_d     = 1'b0;
    plot_cnt_d = (plot_wr  && (plot_cnt_q != 16'hFFFF)) ? plot_cnt_q + 16'd1 : plot_cnt_q;
    rej_cnt_d  = (plot_rej && (rej_cnt_q  != 16'hFFFF)) ? rej_cnt_q  + 16'd1 : rej_cnt_q;

    case (state_q)
      S_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          clr_addr_d = '0;
          state_d    = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_SEND;
      S_SEND: begin
        if (out_ready) begin
          if (last_pix) begin
            x_d     = '0;
            y_d     = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      done_q     <= 1'b0;
      plot_cnt_q <= '0;
      rej_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      done_q     <= done_d;
      plot_cnt_q <= plot_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // outputs; the read register has no reset, so colour is gated by the
  // SEND state to stay zero through reset and between pixels
  // ------------------------------------------------------------------
  assign out_valid = (state_q == S_SEND);
  assign out_pix   = '{x: x_q, y: y_q, colour: (out_valid ? rd_data_q : 3'd0)};

  assign out_x        = out_pix.x;
  assign out_y        = out_pix.y;
  assign out_colour   = out_pix.colour;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign plot_count   = plot_cnt_q;
  assign reject_count = rej_cnt_q;

endmodule
